dmem_mmio_responder: RTL and testbench
======================================

Name: dmem_mmio_responder

Overview:
- Responder on the processor's data-memory bus (address_dmem/data/wren/q_dmem).
- Splits the 12-bit word-address space between the external data RAM and a block of memory-mapped game I/O: key-event FIFO, frame tick timer, score register.
- Sits between the core and the dmem RAM. Gives Tetris software lw/sw access to buttons and game timing.

Parameters:
- MMIO_BASE, 12'hF00, first MMIO word address; all addresses >= MMIO_BASE are MMIO, everything below goes to RAM.
- KEY_DEPTH, 8, key FIFO depth in entries (power of 2).
- KEY_W, 4, key code width.

Ports:
- clock  in  1  master clock, rising edge.
- reset  in  1  asynchronous, active-high.
- address_dmem  in  12  word address from the processor.
- data  in  32  store data from the processor.
- wren  in  1  store enable from the processor.
- q_dmem  out  32  load data to the processor.
- ram_address  out  12  equals address_dmem.
- ram_data  out  32  equals data.
- ram_wren  out  1  wren & (address_dmem < MMIO_BASE).
- ram_q  in  32  RAM read data.
- key_valid  in  1  one-cycle key event strobe, already synchronous to clock.
- key_code  in  KEY_W  key code, valid when key_valid is high.
- score_out  out  32  current SCORE register value.
- tick  out  1  one-cycle pulse on each timer wrap.

Behaviour:
- MMIO register map (offsets from MMIO_BASE):
  - +0 KEY_STATUS (RO; any write clears ovf): bit0 nonempty, bit1 overflow (sticky), bits[7:4] count (zero-extended), other bits 0.
  - +1 KEY_DATA (RO): head entry zero-extended. A read pops the FIFO.
  - +2 TIMER_COUNT: read returns the count; any write clears it to 0.
  - +3 TIMER_PERIOD: read/write, 32 bits.
  - +4 TIMER_FLAG: read returns {31'b0, flag}; any write clears flag.
  - +5 SCORE: read/write, 32 bits.
  - Other MMIO offsets: read 0, writes ignored.
- Load path:
  - q_dmem is combinational from address_dmem: ram_q when address_dmem < MMIO_BASE, otherwise the MMIO mux.
  - Zero-latency, same cycle, as the single-cycle core requires.
- Side effects:
  - All state changes commit on the rising clock edge at the end of the access cycle.
  - KEY_DATA pop fires when address_dmem == MMIO_BASE+1 and wren == 0.
  - A store to KEY_DATA is ignored and does not pop.
- Key FIFO:
  - Push when key_valid = 1.
  - Pop when empty: q_dmem = 0, no state change.
  - Push while full without a simultaneous pop: code dropped, overflow set.
  - Push and pop in the same cycle while full: both happen, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: entry enters the FIFO, the pop returns 0, count becomes 1.
  - Overflow set and clear in the same cycle: set wins.
  - Read/write pointers wrap modulo KEY_DEPTH.
  - Count ranges 0..KEY_DEPTH and is held in a log2(KEY_DEPTH)+1 bit register.
- Timer:
  - count increments by 1 every cycle.
  - If period != 0 and count == period-1: next count = 0, flag sets, tick = 1 for that cycle (registered, asserted the cycle after the wrap edge).
  - period == 0: count free-runs and wraps at 2^32 with no flag and no tick.
  - A TIMER_COUNT write overrides the increment (count = 0 next cycle).
  - A flag clear and flag set in the same cycle: set wins.
  - Writing TIMER_PERIOD does not reset count. If the new period <= count, count runs on to the 2^32 wrap before matching.
- SCORE: written by sw to offset +5; score_out follows the register.
- Reset (asynchronous, any time including mid-access):
  - FIFO emptied, pointers = 0, overflow = 0.
  - count = 0, period = 0, flag = 0, tick = 0, score = 0.
  - q_dmem follows the combinational mux (MMIO reads return post-reset values).
- RAM region: transparent; this block adds no delay or state on RAM accesses.

Test Plan:
- Reset, then lw from address_dmem = 12'hF00 -> q_dmem = 0. sw data = 32'd1234 to 12'hF05 -> next cycle score_out = 1234 and lw 12'hF05 = 1234.
- sw to 12'h010 with wren = 1 -> ram_wren = 1, ram_address = 12'h010. Same sw to 12'hF03 -> ram_wren = 0. lw from 12'h010 with ram_q = 32'hDEADBEEF -> q_dmem = 32'hDEADBEEF.
- Push key codes 3, 7, 9 -> KEY_STATUS = 32'h31. Three lw from 12'hF01 -> 3, 7, 9. Then KEY_STATUS = 0 and a fourth lw returns 0.
- Push 9 codes with no pops -> KEY_STATUS = 32'h83, ninth code dropped. sw to 12'hF00 -> KEY_STATUS = 32'h81. Push and pop in the same cycle while full -> count stays 8, overflow stays 0.
- Set TIMER_PERIOD = 4 -> tick pulses every 4 cycles and TIMER_FLAG reads 1. sw to 12'hF04 on a wrap cycle -> flag remains 1. sw 12'hF02 -> count reads 0 next cycle.
- Assert reset mid-stream with the FIFO holding 5 entries and period = 10 -> all MMIO reads 0 immediately, tick = 0, score_out = 0.

Source files
------------

// File: rtl/dmem_mmio_responder.sv
// Data-memory bus responder: passes word accesses below MMIO_BASE through to the
// dmem RAM and serves the game I/O block (key FIFO, frame timer, score) above it.
module dmem_mmio_responder #(
  parameter logic [11:0] MMIO_BASE = 12'hF00,
  parameter int          KEY_DEPTH = 8,
  parameter int          KEY_W     = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [11:0]      address_dmem,
  input  logic [31:0]      data,
  input  logic             wren,
  output logic [31:0]      q_dmem,
  output logic [11:0]      ram_address,
  output logic [31:0]      ram_data,
  output logic             ram_wren,
  input  logic [31:0]      ram_q,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  output logic [31:0]      score_out,
  output logic             tick
);

  localparam int PTR_W = $clog2(KEY_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [11:0] OFF_KEY_STATUS   = 12'd0;
  localparam logic [11:0] OFF_KEY_DATA     = 12'd1;
  localparam logic [11:0] OFF_TIMER_COUNT  = 12'd2;
  localparam logic [11:0] OFF_TIMER_PERIOD = 12'd3;
  localparam logic [11:0] OFF_TIMER_FLAG   = 12'd4;
  localparam logic [11:0] OFF_SCORE        = 12'd5;

  // Address decode
  logic        is_mmio;
  logic [11:0] mmio_off;
  logic        sel_status, sel_kdata, sel_count, sel_period, sel_flag, sel_score;

  assign is_mmio    = (address_dmem >= MMIO_BASE);
  assign mmio_off   = address_dmem - MMIO_BASE;
  assign sel_status = is_mmio && (mmio_off == OFF_KEY_STATUS);
  assign sel_kdata  = is_mmio && (mmio_off == OFF_KEY_DATA);
  assign sel_count  = is_mmio && (mmio_off == OFF_TIMER_COUNT);
  assign sel_period = is_mmio && (mmio_off == OFF_TIMER_PERIOD);
  assign sel_flag   = is_mmio && (mmio_off == OFF_TIMER_FLAG);
  assign sel_score  = is_mmio && (mmio_off == OFF_SCORE);

  assign ram_address = address_dmem;
  assign ram_data    = data;
  assign ram_wren    = wren && !is_mmio;

  // State registers
  logic [KEY_W-1:0] key_mem [KEY_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] key_cnt_q, key_cnt_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      period_q, period_d;
  logic             flag_q, flag_d;
  logic             tick_q, tick_d;
  logic [31:0]      score_q, score_d;

  logic key_empty, key_full, key_pop, key_push, ovf_set, timer_wrap;

  assign key_empty  = (key_cnt_q == '0);
  assign key_full   = (key_cnt_q == CNT_W'(KEY_DEPTH));
  assign key_pop    = sel_kdata && !wren && !key_empty;
  // A full FIFO still accepts a key when the same cycle frees the head slot.
  assign key_push   = key_valid && (!key_full || key_pop);
  assign ovf_set    = key_valid && key_full && !key_pop;
  assign timer_wrap = (period_q != '0) && (count_q == period_q - 32'd1);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    key_cnt_d = key_cnt_q;
    ovf_d     = ovf_q;
    count_d   = count_q + 32'd1;
    period_d  = period_q;
    flag_d    = flag_q;
    tick_d    = timer_wrap;
    score_d   = score_q;

    if (key_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (key_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({key_push, key_pop})
      2'b10:   key_cnt_d = key_cnt_q + CNT_W'(1);
      2'b01:   key_cnt_d = key_cnt_q - CNT_W'(1);
      default: key_cnt_d = key_cnt_q;
    endcase

    // Clears are applied first so a coincident set wins.
    if (wren && sel_status) ovf_d = 1'b0;
    if (ovf_set)            ovf_d = 1'b1;

    if (timer_wrap)        count_d = '0;
    if (wren && sel_count) count_d = '0;
    if (wren && sel_flag)  flag_d  = 1'b0;
    if (timer_wrap)        flag_d  = 1'b1;

    if (wren && sel_period) period_d = data;
    if (wren && sel_score)  score_d  = data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      key_cnt_q <= '0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
      period_q  <= '0;
      flag_q    <= 1'b0;
      tick_q    <= 1'b0;
      score_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      key_cnt_q <= key_cnt_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
      period_q  <= period_d;
      flag_q    <= flag_d;
      tick_q    <= tick_d;
      score_q   <= score_d;
    end
  end

  // NOTE: the key storage has no reset; an entry is only ever read while the
  // count says it holds valid data, so stale contents are never observable.
  always_ff @(posedge clock) begin
    if (key_push) key_mem[wr_ptr_q] <= key_code;
  end

  // Load mux (combinational, same-cycle)
  logic [31:0] mmio_rdata;

  always_comb begin
    mmio_rdata = '0;
    if (sel_status) begin
      mmio_rdata[0]           = !key_empty;
      mmio_rdata[1]           = ovf_q;
      mmio_rdata[4 +: CNT_W]  = key_cnt_q;
    end else if (sel_kdata) begin
      if (!key_empty) mmio_rdata[KEY_W-1:0] = key_mem[rd_ptr_q];
    end else if (sel_count) begin
      mmio_rdata = count_q;
    end else if (sel_period) begin
      mmio_rdata = period_q;
    end else if (sel_flag) begin
      mmio_rdata[0] = flag_q;
    end else if (sel_score) begin
      mmio_rdata = score_q;
    end
  end

  assign q_dmem    = is_mmio ? mmio_rdata : ram_q;
  assign score_out = score_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench for dmem_mmio_responder: a vector table for the basic map,
// then hand-written sequences for FIFO overflow, timer wrap and mid-stream reset.
module tb_dmem_mmio_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [11:0] ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [31:0] score_out;
  logic        tick;

  dmem_mmio_responder dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .ram_address  (ram_address),
    .ram_data     (ram_data),
    .ram_wren     (ram_wren),
    .ram_q        (ram_q),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .score_out    (score_out),
    .tick         (tick)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rq;
    logic        kv;
    logic [3:0]  kc;
    logic [31:0] exp_q;
    logic        exp_ram_wren;
    logic [31:0] exp_score;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  localparam int NVEC = 25;
  vec_t vecs [NVEC];
  exp_t sb [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic drive(input logic [11:0] a, input logic [31:0] d, input logic we,
                       input logic kv, input logic [3:0] kc, input logic [31:0] rq);
    address_dmem = a;
    data         = d;
    wren         = we;
    key_valid    = kv;
    key_code     = kc;
    ram_q        = rq;
  endtask

  task automatic expect_q(input string name, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic sample_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, q_dmem, e.val);
    end
  endtask

  task automatic step();
    @(negedge clock);
    sample_sb();
    @(posedge clock);
    #1;
  endtask

  task automatic lw(input logic [11:0] a, input string name, input logic [31:0] v);
    drive(a, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    expect_q(name, v);
    step();
  endtask

  task automatic sw(input logic [11:0] a, input logic [31:0] d, input string name,
                    input logic [31:0] v);
    drive(a, d, 1'b1, 1'b0, 4'd0, 32'd0);
    expect_q(name, v);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // addr, wdata, we, ram_q, key_valid, key_code, exp_q, exp_ram_wren, exp_score
    vecs[0]  = '{12'hF00, 32'd0,    1'b0, 32'd0,        1'b0, 4'd0, 32'd0,        1'b0, 32'd0};
    vecs[1]  = '{12'hF05, 32'd1234, 1'b1, 32'd0,        1'b0, 4'd0, 32'd0,        1'b0, 32'd0};
    vecs[2]  = '{12'hF05, 32'd0,    1'b0, 32'd0,        1'b0, 4'd0, 32'd1234,     1'b0, 32'd1234};
    vecs[3]  = '{12'h010, 32'd55,   1'b1, 32'd0,        1'b0, 4'd0, 32'd0,        1'b1, 32'd1234};
    vecs[4]  = '{12'hF03, 32'd0,    1'b1, 32'd0,        1'b0, 4'd0, 32'd0,        1'b0, 32'd1234};
    vecs[5]  = '{12'h010, 32'd0,    1'b0, 32'hDEADBEEF, 1'b0, 4'd0, 32'hDEADBEEF, 1'b0, 32'd1234};
    vecs[6]  = '{12'h010, 32'd0,    1'b0, 32'd0,        1'b1, 4'd3, 32'd0,        1'b0, 32'd1234};
    vecs[7]  = '{12'h010, 32'd0,    1'b0, 32'd0,        1'b1, 4'd7, 32'd0,        1'b0, 32'd1234};
    vecs[8]  = '{12'h010, 32'd0,    1'b0, 32'd0,        1'b1, 4'd9, 32'd0,        1'b0, 32'd1234};
    vecs[9]  = '{12'hF00, 32'd0,    1'b0, 32'd0,        1'b0, 4'd0, 32'h31,       1'b0, 32'd1234};
    vecs[10] = '{12'hF01, 32'd0,    1'b0, 32'd0,        1'b0, 4'd0, 32'd3,        1'b0, 32'd1234};
    vecs[11] = '{12'hF01, 32'd0,    1'b0, 32'd0,        1'b0, 4'd0, 32'd7,        1'b0, 32'd1234};
    vecs[12] = '{12'hF01, 32'd0,    1'b0, 32'd0,        1'b0, 4'd0, 32'd9,        1'b0, 32'd1234};
    vecs[13] = '{12'hF00, 32'd0,    1'b0, 32'd0,        1'b0, 4'd0, 32'd0,        1'b0, 32'd1234};
    vecs[14] = '{12'hF01, 32'd0,    1'b0, 32'd0,        1'b0, 4'd0, 32'd0,        1'b0, 32'd1234};
    vecs[15] = '{12'hF00, 32'd0,    1'b0, 32'd0,        1'b0, 4'd0, 32'd0,        1'b0, 32'd1234};
    vecs[16] = '{12'hF07, 32'hFFFF, 1'b1, 32'd0,        1'b0, 4'd0, 32'd0,        1'b0, 32'd1234};
    vecs[17] = '{12'hF07, 32'd0,    1'b0, 32'd0,        1'b0, 4'd0, 32'd0,        1'b0, 32'd1234};
    vecs[18] = '{12'hF01, 32'hAB,   1'b1, 32'd0,        1'b1, 4'd6, 32'd0,        1'b0, 32'd1234};
    vecs[19] = '{12'hF01, 32'hAB,   1'b1, 32'd0,        1'b0, 4'd0, 32'd6,        1'b0, 32'd1234};
    vecs[20] = '{12'hF00, 32'd0,    1'b0, 32'd0,        1'b0, 4'd0, 32'h11,       1'b0, 32'd1234};
    vecs[21] = '{12'hF01, 32'd0,    1'b0, 32'd0,        1'b0, 4'd0, 32'd6,        1'b0, 32'd1234};
    vecs[22] = '{12'hF00, 32'd0,    1'b0, 32'd0,        1'b0, 4'd0, 32'd0,        1'b0, 32'd1234};
    vecs[23] = '{12'hEFF, 32'd0,    1'b1, 32'h1111,     1'b0, 4'd0, 32'h1111,     1'b1, 32'd1234};
    vecs[24] = '{12'hFFF, 32'd0,    1'b0, 32'h2222,     1'b0, 4'd0, 32'd0,        1'b0, 32'd1234};

    reset = 1'b1;
    drive(12'h000, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    #12;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Vector table
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].kv, vecs[i].kc, vecs[i].rq);
      expect_q($sformatf("vec%0d q_dmem", i), vecs[i].exp_q);
      @(negedge clock);
      sample_sb();
      check($sformatf("vec%0d ram_wren", i), {31'd0, ram_wren}, {31'd0, vecs[i].exp_ram_wren});
      check($sformatf("vec%0d ram_address", i), {20'd0, ram_address}, {20'd0, vecs[i].addr});
      check($sformatf("vec%0d ram_data", i), ram_data, vecs[i].wdata);
      check($sformatf("vec%0d score_out", i), score_out, vecs[i].exp_score);
      @(posedge clock);
      #1;
    end

    // FIFO overflow, push+pop while full, overflow set/clear collision
    for (int i = 1; i <= 9; i++) begin
      drive(12'h000, 32'd0, 1'b0, 1'b1, i[3:0], 32'd0);
      step();
    end
    lw(12'hF00, "full status", 32'h83);
    sw(12'hF00, 32'd0, "status before ovf clear", 32'h83);
    lw(12'hF00, "status after ovf clear", 32'h81);
    drive(12'hF01, 32'd0, 1'b0, 1'b1, 4'hA, 32'd0);
    expect_q("pop while full+push", 32'd1);
    step();
    lw(12'hF00, "status after full push+pop", 32'h81);
    drive(12'hF00, 32'd0, 1'b1, 1'b1, 4'hB, 32'd0);
    expect_q("status at ovf set/clear", 32'h81);
    step();
    lw(12'hF00, "ovf set wins", 32'h83);
    for (int j = 0; j < 8; j++) begin
      lw(12'hF01, $sformatf("drain%0d", j), (j < 7) ? 32'(j + 2) : 32'hA);
    end
    lw(12'hF00, "empty with sticky ovf", 32'h02);
    sw(12'hF00, 32'd0, "ovf clear on empty", 32'h02);
    lw(12'hF00, "status cleared", 32'h00);
    drive(12'hF01, 32'd0, 1'b0, 1'b1, 4'd5, 32'd0);
    expect_q("pop+push while empty", 32'd0);
    step();
    lw(12'hF00, "status after empty push+pop", 32'h11);
    lw(12'hF01, "entry from empty push+pop", 32'd5);
    lw(12'hF00, "status drained", 32'h00);

    // Timer: clear count, period 4, watch count and tick pulses
    drive(12'hF02, 32'd0, 1'b1, 1'b0, 4'd0, 32'd0);
    step();
    sw(12'hF03, 32'd4, "period before write", 32'd0);
    for (int k = 0; k < 12; k++) begin
      drive(12'hF02, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
      expect_q($sformatf("count k%0d", k), 32'((k + 1) % 4));
      @(negedge clock);
      sample_sb();
      check($sformatf("tick k%0d", k), {31'd0, tick}, (k % 4 == 3) ? 32'd1 : 32'd0);
      @(posedge clock);
      #1;
    end
    lw(12'hF02, "count k12", 32'd1);
    lw(12'hF02, "count k13", 32'd2);
    sw(12'hF04, 32'd0, "flag clear on wrap cycle", 32'd1);
    drive(12'hF04, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    expect_q("flag set wins", 32'd1);
    @(negedge clock);
    sample_sb();
    check("tick k15", {31'd0, tick}, 32'd1);
    @(posedge clock);
    #1;
    sw(12'hF04, 32'd0, "flag clear", 32'd1);
    lw(12'hF04, "flag cleared", 32'd0);
    lw(12'hF02, "count k18", 32'd3);
    sw(12'hF02, 32'd0, "count clear", 32'd0);
    lw(12'hF02, "count after clear", 32'd0);
    lw(12'hF02, "count resumes", 32'd1);

    // Mid-stream reset with FIFO holding 5 entries and period 10
    for (int i = 0; i < 5; i++) begin
      drive(12'h000, 32'd0, 1'b0, 1'b1, 4'(i + 1), 32'd0);
      step();
    end
    sw(12'hF03, 32'd10, "period before 10", 32'd4);
    sw(12'hF05, 32'd777, "score before 777", 32'd1234);
    lw(12'hF00, "status pre-reset", 32'h51);
    drive(12'hF00, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    reset = 1'b1;
    #1;
    for (int a = 0; a < 6; a++) begin
      address_dmem = 12'hF00 + 12'(a);
      #1;
      check($sformatf("reset read F0%0d", a), q_dmem, 32'd0);
    end
    check("reset tick", {31'd0, tick}, 32'd0);
    check("reset score_out", score_out, 32'd0);
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b0;
    @(posedge clock);
    #1;
    lw(12'hF02, "count after reset", 32'd1);
    lw(12'hF00, "status after reset", 32'd0);
    lw(12'hF01, "key data after reset", 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
